s_mem_arbiter: RTL and testbench

Grants exclusive, lock-based access to the single-port 256x8 S memory among three requesters: the S-init populator (port 0), the key-schedule shuffler (port 1) and the PRGA/decrypt engine (port 2). It replaces the ad-hoc state-driven mux in the top level. Each requester raises a request, waits for its grant, drives address, data and write-enable for as long as it needs, then drops its request to release the memory. Read data from the memory is broadcast to all requesters.

---
 rtl/s_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_s_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter
// Lock-based arbiter for the single-port 256x8 S memory shared by the
// S-init populator (port 0), the key-schedule shuffler (port 1) and the
// PRGA/decrypt engine (port 2). A requester raises req, waits for gnt,
// drives the memory for as long as it needs, then drops req to release it.
// Fixed priority on arbitration (0 > 1 > 2), no preemption once granted.
//
// Optional feature macro: S_MEM_ARB_WATCHDOG_EN
//   defined   : hold watchdog revokes a grant held MAX_HOLD cycles, pulses
//               timeout and masks the revoked port until its req drops.
//   undefined : grants are held indefinitely, timeout is tied low.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate among unmasked requests each cycle
// GRANT  | one port owns the memory; held while its req stays high

module s_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 1024
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [2:0]          req,
  input  logic [3*ADDR_W-1:0] addr_in,
  input  logic [3*DATA_W-1:0] data_in,
  input  logic [2:0]          wren_in,
  output logic [2:0]          gnt,
  output logic [1:0]          owner,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_q,
  output logic [DATA_W-1:0]   q_out,
  output logic                timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [1:0] NO_OWNER = 2'b11;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [2:0] gnt_nxt;
  logic [1:0] owner_nxt;
  logic       busy_nxt;

  logic [2:0] eligible;
  logic [1:0] pick;
  logic       pick_vld;
  logic       req_owner;
  logic       revoke;

`ifdef S_MEM_ARB_WATCHDOG_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        mask;
  logic [2:0]        mask_nxt;

  // A revoked port stays out of arbitration until its request drops
  assign eligible = req & ~mask;
  assign revoke   = (state == ST_GRANT) && req_owner && (hold_cnt == HOLD_LAST);

  // Mask bits clear once the port's req is seen low; set on a revoke
  always_comb begin
    mask_nxt = mask & req;
    if (revoke) begin
      mask_nxt = mask_nxt | gnt;
    end
  end

  // Hold counter restarts on every grant, timeout is a registered pulse
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      mask     <= 3'b000;
      timeout  <= 1'b0;
    end else begin
      mask    <= mask_nxt;
      timeout <= revoke;
      if (state == ST_GRANT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign eligible = req;
  assign revoke   = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Fixed priority pick: lowest eligible index wins
  always_comb begin
    pick_vld = |eligible;
    pick     = 2'd0;
    if (eligible[0]) begin
      pick = 2'd0;
    end else if (eligible[1]) begin
      pick = 2'd1;
    end else if (eligible[2]) begin
      pick = 2'd2;
    end
  end

  // Request line of the current owner; low when nobody owns the memory
  always_comb begin
    req_owner = 1'b0;
    case (owner)
      2'd0:    req_owner = req[0];
      2'd1:    req_owner = req[1];
      2'd2:    req_owner = req[2];
      default: req_owner = 1'b0;
    endcase
  end

  // Next-state logic for the grant FSM
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    busy_nxt  = busy;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = 3'b001 << pick;
          owner_nxt = pick;
          busy_nxt  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!req_owner || revoke) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = 3'b000;
          owner_nxt = NO_OWNER;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = 3'b000;
        owner_nxt = NO_OWNER;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Grant FSM registers; reset drops any ownership immediately
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      gnt   <= 3'b000;
      owner <= NO_OWNER;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      busy  <= busy_nxt;
    end
  end

  // Memory mux driven from the owner register; busy gates wren so a write
  // can never leak through without a grant
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    case (owner)
      2'd0: begin
        mem_address = addr_in[0*ADDR_W +: ADDR_W];
        mem_data    = data_in[0*DATA_W +: DATA_W];
        mem_wren    = wren_in[0] & busy;
      end
      2'd1: begin
        mem_address = addr_in[1*ADDR_W +: ADDR_W];
        mem_data    = data_in[1*DATA_W +: DATA_W];
        mem_wren    = wren_in[1] & busy;
      end
      2'd2: begin
        mem_address = addr_in[2*ADDR_W +: ADDR_W];
        mem_data    = data_in[2*DATA_W +: DATA_W];
        mem_wren    = wren_in[2] & busy;
      end
      default: begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
      end
    endcase
  end

  // Read data is broadcast unchanged; the memory supplies the latency
  assign q_out = mem_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Testbench for s_mem_arbiter: directed scenarios followed by randomized
// requester traffic, all checked every cycle against a behavioural model
// and a reference copy of the S memory.

module tb_s_mem_arbiter;

  localparam int HOLD = 16;
`ifdef S_MEM_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [2:0]  req      = 3'b000;
  logic [23:0] addr_in  = '0;
  logic [23:0] data_in  = '0;
  logic [2:0]  wren_in  = 3'b000;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q;
  logic [7:0]  q_out;
  logic        timeout;

  s_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(HOLD)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req(req), .addr_in(addr_in),
    .data_in(data_in), .wren_in(wren_in), .gnt(gnt), .owner(owner),
    .busy(busy), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .q_out(q_out), .timeout(timeout)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // S memory attached to the DUT, one-cycle registered read
  logic [7:0] sim_mem [256];
  always @(posedge CLOCK_50) begin
    mem_q <= sim_mem[mem_address];
    if (mem_wren) sim_mem[mem_address] <= mem_data;
  end

  // Behavioural reference: who owns the memory, how long, who is barred
  int         m_owner = -1;
  int         m_hold  = 0;
  bit [2:0]   m_mask  = 3'b000;
  bit         m_to    = 1'b0;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_q   = 8'h00;

  function automatic logic [7:0] e_addr();
    if (m_owner < 0) return 8'h00;
    return addr_in[m_owner*8 +: 8];
  endfunction
  function automatic logic [7:0] e_data();
    if (m_owner < 0) return 8'h00;
    return data_in[m_owner*8 +: 8];
  endfunction
  function automatic logic e_wren();
    if (m_owner < 0) return 1'b0;
    return wren_in[m_owner];
  endfunction

  always @(negedge reset_n) begin
    m_owner = -1;
    m_hold  = 0;
    m_mask  = 3'b000;
    m_to    = 1'b0;
  end

  always @(posedge CLOCK_50) begin
    bit [2:0] new_mask;
    ref_q = ref_mem[e_addr()];
    if (e_wren()) ref_mem[e_addr()] = e_data();
    if (reset_n) begin
      m_to     = 1'b0;
      new_mask = m_mask & req;
      if (m_owner < 0) begin
        for (int k = 2; k >= 0; k--)
          if (req[k] && !m_mask[k]) m_owner = k;
        m_hold = 0;
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else if (WD && m_hold == HOLD - 1) begin
        new_mask[m_owner] = 1'b1;
        m_to    = 1'b1;
        m_owner = -1;
      end else begin
        m_hold++;
      end
      m_mask = new_mask;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge CLOCK_50) begin
    if (chk_on) begin
      check("gnt",  gnt,  (m_owner < 0) ? 3'b000 : (3'b001 << m_owner));
      check("owner", owner, (m_owner < 0) ? 2'b11 : m_owner[1:0]);
      check("busy", busy, m_owner >= 0);
      check("mem_address", mem_address, e_addr());
      check("mem_data", mem_data, e_data());
      check("mem_wren", mem_wren, e_wren());
      check("q_out", q_out, ref_q);
      check("timeout", timeout, m_to);
    end
  end

  task automatic cyc(input logic [2:0] r, input logic [23:0] a,
                     input logic [23:0] d, input logic [2:0] w);
    @(negedge CLOCK_50);
    #1;
    req = r; addr_in = a; data_in = d; wren_in = w;
  endtask

  int n_hi;
  int n_to;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sim_mem[i] = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end
    repeat (2) @(negedge CLOCK_50);
    #2 reset_n = 1'b1;
    chk_on = 1'b1;
    check("reset_gnt", gnt, 3'b000);
    check("reset_owner", owner, 2'b11);

    // Single requester: write A5 to 05 then read it back
    cyc(3'b010, 24'h000500, 24'h00A500, 3'b000);
    cyc(3'b010, 24'h000500, 24'h00A500, 3'b010);
    check("single_gnt", gnt, 3'b010);
    cyc(3'b010, 24'h000500, 24'h000000, 3'b000);
    cyc(3'b000, 24'h000000, 24'h000000, 3'b000);
    check("single_readback", q_out, 8'hA5);

    // Simultaneous requests, served 0 then 1 then 2 with dead cycles
    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    cyc(3'b111, 24'h302010, 24'h332211, 3'b000);
    cyc(3'b110, 24'h302010, 24'h332211, 3'b111);
    check("simul_p0", gnt, 3'b001);
    cyc(3'b110, 24'h302010, 24'h332211, 3'b111);
    check("simul_dead1", gnt, 3'b000);
    check("simul_dead1_wren", mem_wren, 1'b0);
    cyc(3'b100, 24'h302010, 24'h332211, 3'b000);
    check("simul_p1", gnt, 3'b010);
    cyc(3'b100, 24'h302010, 24'h332211, 3'b111);
    check("simul_dead2", gnt, 3'b000);
    check("simul_dead2_wren", mem_wren, 1'b0);
    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    check("simul_p2", gnt, 3'b100);

    // No preemption: port 0 waits for port 2 to release
    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    cyc(3'b100, 24'h0, 24'h0, 3'b000);
    cyc(3'b101, 24'h0, 24'h0, 3'b000);
    check("nopre_a", gnt, 3'b100);
    cyc(3'b101, 24'h0, 24'h0, 3'b000);
    check("nopre_b", gnt, 3'b100);
    cyc(3'b001, 24'h0, 24'h0, 3'b000);
    check("nopre_c", gnt, 3'b100);
    cyc(3'b001, 24'h0, 24'h0, 3'b000);
    check("nopre_dead", gnt, 3'b000);
    cyc(3'b001, 24'h000020, 24'h0, 3'b000);
    check("nopre_p0", gnt, 3'b001);

    // Write without grant: port 1 strobes wren while port 0 reads 0x20
    cyc(3'b001, 24'h002020, 24'h007700, 3'b010);
    #1 check("nogrant_wren", mem_wren, 1'b0);
    cyc(3'b001, 24'h000020, 24'h0, 3'b000);
    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    check("nogrant_readback", q_out, 8'h1C);

    // Reset while port 1 holds the grant
    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    cyc(3'b010, 24'h000900, 24'h005500, 3'b010);
    cyc(3'b010, 24'h000900, 24'h005500, 3'b010);
    check("prereset_gnt", gnt, 3'b010);
    #2 reset_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 3'b000);
    check("rst_owner", owner, 2'b11);
    check("rst_busy", busy, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    reset_n = 1'b1;

    // Long hold by port 0 with port 1 pending
    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    cyc(3'b011, 24'h0, 24'h0, 3'b000);
    n_hi = 0;
    n_to = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (gnt == 3'b001) n_hi++;
      if (timeout) n_to++;
      if (n_hi > 0 && gnt != 3'b001) break;
    end
`ifdef S_MEM_ARB_WATCHDOG_EN
    check("wd_hold_cycles", n_hi, HOLD);
    check("wd_timeout_pulses", n_to, 1);
    @(negedge CLOCK_50);
    check("wd_next_p1", gnt, 3'b010);
    #1 req = 3'b001;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      check("wd_masked", gnt, 3'b000);
    end
    #1 req = 3'b000;
    cyc(3'b001, 24'h0, 24'h0, 3'b000);
    cyc(3'b001, 24'h0, 24'h0, 3'b000);
    check("wd_regrant_p0", gnt, 3'b001);
`else
    check("hold_cycles", n_hi, 40);
    check("hold_timeout", n_to, 0);
`endif
    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    cyc(3'b000, 24'h0, 24'h0, 3'b000);

    // Randomized traffic: short holds first, long holds later
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] r;
      r = req;
      for (int k = 0; k < 3; k++) begin
        if (!r[k]) r[k] = ($urandom_range(3) == 0);
        else       r[k] = !($urandom_range((i < 1500) ? 7 : 39) == 0);
      end
      cyc(r, 24'($urandom), 24'($urandom), 3'($urandom));
      if (i == 1200) begin
        #2 reset_n = 1'b0;
        @(negedge CLOCK_50);
        #3 reset_n = 1'b1;
      end
    end

    cyc(3'b000, 24'h0, 24'h0, 3'b000);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
